mem_write_arbiter: RTL and testbench

- Shares one memory write port among NUM_CLIENTS write requesters, for example the conv, pool and FC result writers.
- Arbitration is round-robin and burst-locked: once a client is granted, it owns the port until its beat marked "last" is accepted by memory.
- Sits between the engine write masters (client side) and the SRAM write controller (memory side).
- Includes a watchdog that releases the port if the owner stalls mid-burst, so a hung engine cannot deadlock the write path.

---
 rtl/mem_write_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_write_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_arbiter.sv
// mem_write_arbiter: shares one memory write port among NUM_CLIENTS write
// masters. Round-robin selection, the port stays locked to the owner until its
// last beat is accepted, and a watchdog frees the port from a stalled owner.
module mem_write_arbiter #(
   parameter int NUM_CLIENTS       = 4,
   parameter int WORD_WIDTH        = 8,
   parameter int NUM_WORDS_IN_LINE = 32,
   parameter int ADDR_WIDTH        = 19,
   parameter int TIMEOUT_CYC       = 256,
   localparam int LW  = WORD_WIDTH * NUM_WORDS_IN_LINE,
   localparam int SW  = ADDR_WIDTH - ADDR_WIDTH / 8,
   localparam int LVW = $clog2(LW / 8),
   localparam int IDW = $clog2(NUM_CLIENTS)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_CLIENTS-1:0]     cl_req,
   input  logic [NUM_CLIENTS-1:0]     cl_last,
   input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] cl_start_addr,
   input  logic [NUM_CLIENTS*SW-1:0]  cl_size_bytes,
   input  logic [NUM_CLIENTS*LW-1:0]  cl_data,
   input  logic [NUM_CLIENTS*LVW-1:0] cl_last_valid,
   output logic [NUM_CLIENTS-1:0]     cl_gnt,
   output logic                       mem_req,
   input  logic                       mem_gnt,
   output logic                       mem_last,
   output logic [ADDR_WIDTH-1:0]      mem_start_addr,
   output logic [SW-1:0]              mem_size_bytes,
   output logic [LW-1:0]              mem_data,
   output logic [LVW-1:0]             mem_last_valid,
   output logic                       busy,
   output logic [IDW-1:0]             owner_id,
   output logic                       err_abort
);

   localparam int WDW = $clog2(TIMEOUT_CYC);

   typedef enum logic {S_IDLE, S_BURST} state_t;

   state_t                r_state, w_state_nxt;
   logic [IDW-1:0]        r_rr_ptr, w_rr_nxt;
   logic [IDW-1:0]        r_owner, w_owner_nxt;
   logic [IDW-1:0]        w_owner_inc, w_pick, w_cand;
   logic [WDW-1:0]        r_wd_cnt, w_wd_nxt;
   logic                  w_found;
   logic                  w_own_req, w_own_last;
   logic [ADDR_WIDTH-1:0] w_own_addr;
   logic [SW-1:0]         w_own_size;
   logic [LW-1:0]         w_own_data;
   logic [LVW-1:0]        w_own_lv;

   assign w_owner_inc = (r_owner == IDW'(NUM_CLIENTS - 1)) ? '0 : r_owner + 1'b1;

   // Round-robin pick: first requester at or above rr_ptr, wrapping around.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_cand  = '0;
      for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
         w_cand = IDW'((32'(r_rr_ptr) + i) % NUM_CLIENTS);
         if (!w_found && cl_req[w_cand]) begin
            w_found = 1'b1;
            w_pick  = w_cand;
         end
      end
   end

   // Select the current owner's request and payload slices.
   always_comb begin
      w_own_req  = 1'b0;
      w_own_last = 1'b0;
      w_own_addr = '0;
      w_own_size = '0;
      w_own_data = '0;
      w_own_lv   = '0;
      for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
         if (r_owner == IDW'(i)) begin
            w_own_req  = cl_req[i];
            w_own_last = cl_last[i];
            w_own_addr = cl_start_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            w_own_size = cl_size_bytes[i*SW +: SW];
            w_own_data = cl_data[i*LW +: LW];
            w_own_lv   = cl_last_valid[i*LVW +: LVW];
         end
      end
   end

   // Next-state, watchdog and handshake logic.
   always_comb begin
      w_state_nxt = r_state;
      w_rr_nxt    = r_rr_ptr;
      w_owner_nxt = r_owner;
      w_wd_nxt    = r_wd_cnt;
      mem_req     = 1'b0;
      cl_gnt      = '0;
      err_abort   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_wd_nxt = '0;
            if (w_found) begin
               w_owner_nxt = w_pick;
               w_state_nxt = S_BURST;
            end
         end
         S_BURST: begin
            mem_req = w_own_req;
            for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
               if (r_owner == IDW'(i)) cl_gnt[i] = mem_gnt & w_own_req;
            end
            if (w_own_req) begin
               w_wd_nxt = '0;
               if (mem_gnt && w_own_last) begin
                  w_state_nxt = S_IDLE;
                  w_rr_nxt    = w_owner_inc;
               end
            end else if (r_wd_cnt == WDW'(TIMEOUT_CYC - 1)) begin
               err_abort   = 1'b1;
               w_state_nxt = S_IDLE;
               w_rr_nxt    = w_owner_inc;
               w_wd_nxt    = '0;
            end else begin
               w_wd_nxt = r_wd_cnt + 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State, pointer, owner and watchdog registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_rr_ptr <= '0;
         r_owner  <= '0;
         r_wd_cnt <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_rr_ptr <= w_rr_nxt;
         r_owner  <= w_owner_nxt;
         r_wd_cnt <= w_wd_nxt;
      end
   end

   // Memory-side payload is driven only while a burst is owned.
   always_comb begin
      busy           = (r_state == S_BURST);
      owner_id       = r_owner;
      mem_last       = busy & w_own_last;
      mem_start_addr = busy ? w_own_addr : '0;
      mem_size_bytes = busy ? w_own_size : '0;
      mem_data       = busy ? w_own_data : '0;
      mem_last_valid = busy ? w_own_lv   : '0;
   end

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Testbench for mem_write_arbiter: directed reset/latency/watchdog/reset
// scenarios followed by randomized multi-client rounds checked by a scoreboard.
module tb_mem_write_arbiter;

   localparam int N   = 4;
   localparam int WW  = 8;
   localparam int NW  = 32;
   localparam int AW  = 19;
   localparam int TO  = 16;
   localparam int LW  = WW * NW;
   localparam int SW  = AW - AW / 8;
   localparam int LVW = $clog2(LW / 8);
   localparam int IDW = $clog2(N);

   typedef struct {
      int             id;
      logic [LW-1:0]  data;
      logic [AW-1:0]  addr;
      logic [SW-1:0]  size;
      logic [LVW-1:0] lv;
      logic           last;
   } beat_t;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [N-1:0]       cl_req, cl_last, cl_gnt;
   logic [N*AW-1:0]    cl_start_addr;
   logic [N*SW-1:0]    cl_size_bytes;
   logic [N*LW-1:0]    cl_data;
   logic [N*LVW-1:0]   cl_last_valid;
   logic               mem_req, mem_gnt, mem_last, busy, err_abort;
   logic [AW-1:0]      mem_start_addr;
   logic [SW-1:0]      mem_size_bytes;
   logic [LW-1:0]      mem_data;
   logic [LVW-1:0]     mem_last_valid;
   logic [IDW-1:0]     owner_id;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   beat_t       exp_q[$];
   beat_t       me;
   logic [N-1:0] g_snap = '0;
   logic [N-1:0] oh;
   bit          mon_en = 1'b0;
   int          m_rr = 0;

   mem_write_arbiter #(
      .NUM_CLIENTS(N), .WORD_WIDTH(WW), .NUM_WORDS_IN_LINE(NW),
      .ADDR_WIDTH(AW), .TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cl_req(cl_req), .cl_last(cl_last),
      .cl_start_addr(cl_start_addr), .cl_size_bytes(cl_size_bytes),
      .cl_data(cl_data), .cl_last_valid(cl_last_valid), .cl_gnt(cl_gnt),
      .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_last(mem_last),
      .mem_start_addr(mem_start_addr), .mem_size_bytes(mem_size_bytes),
      .mem_data(mem_data), .mem_last_valid(mem_last_valid), .busy(busy),
      .owner_id(owner_id), .err_abort(err_abort)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] r;
      r = '0;
      for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_client(input int c, input logic req, input logic last, input logic [LW-1:0] d,
                             input logic [AW-1:0] a, input logic [SW-1:0] s, input logic [LVW-1:0] lv);
      cl_req[c]                 = req;
      cl_last[c]                = last;
      cl_data[c*LW +: LW]       = d;
      cl_start_addr[c*AW +: AW] = a;
      cl_size_bytes[c*SW +: SW] = s;
      cl_last_valid[c*LVW +: LVW] = lv;
   endtask

   // Monitor: snapshot accepted beats and compare them against the scoreboard.
   always @(negedge clk) begin
      g_snap = cl_gnt;
      if (mon_en && rst_n) begin
         if (!mem_gnt) check("gnt_without_mem_gnt", LW'(cl_gnt), '0);
         if (cl_gnt != '0) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", LW'(cl_gnt), '0);
            end else begin
               me = exp_q.pop_front();
               oh = '0;
               oh[me.id] = 1'b1;
               check("sb_gnt_onehot", LW'(cl_gnt), LW'(oh));
               check("sb_mem_req", LW'(mem_req), LW'(1'b1));
               check("sb_data", mem_data, me.data);
               check("sb_addr", LW'(mem_start_addr), LW'(me.addr));
               check("sb_size", LW'(mem_size_bytes), LW'(me.size));
               check("sb_lv", LW'(mem_last_valid), LW'(me.lv));
               check("sb_last", LW'(mem_last), LW'(me.last));
               check("sb_owner", LW'(owner_id), LW'(me.id));
            end
         end
      end
   end

   // One round: a random subset of clients requests together; the expected beat
   // order follows the round-robin rule from the modelled pointer.
   task automatic run_round(input logic [N-1:0] mask);
      int             nb[N], bi[N], drop[N];
      bit             started[N];
      logic [LW-1:0]  bd[N][4];
      logic [AW-1:0]  ba[N];
      logic [SW-1:0]  bs[N];
      logic [LVW-1:0] bl[N];
      int             remaining, cycles, last_c, cc;
      beat_t          e;
      remaining = 0;
      last_c    = 0;
      for (int c = 0; c < N; c++) begin
         nb[c] = mask[c] ? int'($urandom_range(1, 4)) : 0;
         bi[c] = 0;
         drop[c] = 0;
         started[c] = 1'b0;
         ba[c] = AW'($urandom);
         bs[c] = SW'($urandom);
         bl[c] = LVW'($urandom);
         for (int b = 0; b < 4; b++) bd[c][b] = rand_line();
         if (mask[c]) remaining++;
      end
      for (int k = 0; k < N; k++) begin
         cc = (m_rr + k) % N;
         if (mask[cc]) begin
            for (int b = 0; b < nb[cc]; b++) begin
               e.id = cc; e.data = bd[cc][b]; e.addr = ba[cc];
               e.size = bs[cc]; e.lv = bl[cc]; e.last = (b == nb[cc] - 1);
               exp_q.push_back(e);
            end
            last_c = cc;
         end
      end
      if (mask != '0) m_rr = (last_c + 1) % N;
      for (int c = 0; c < N; c++)
         set_client(c, mask[c], nb[c] == 1, bd[c][0], ba[c], bs[c], bl[c]);
      mem_gnt = ($urandom_range(0, 3) != 0);
      cycles = 0;
      while (remaining > 0 && cycles < 3000) begin
         tick();
         cycles++;
         for (int c = 0; c < N; c++) begin
            if (g_snap[c] && mask[c] && bi[c] < nb[c]) begin
               started[c] = 1'b1;
               bi[c]++;
               if (bi[c] >= nb[c]) begin
                  cl_req[c] = 1'b0;
                  remaining--;
               end else begin
                  cl_data[c*LW +: LW] = bd[c][bi[c]];
                  cl_last[c] = (bi[c] == nb[c] - 1);
               end
            end
         end
         for (int c = 0; c < N; c++) begin
            if (mask[c] && started[c] && bi[c] < nb[c]) begin
               if (drop[c] > 0) begin
                  drop[c]--;
                  cl_req[c] = (drop[c] == 0);
               end else if ($urandom_range(0, 7) == 0) begin
                  drop[c] = int'($urandom_range(1, 3));
                  cl_req[c] = 1'b0;
               end
            end
         end
         mem_gnt = ($urandom_range(0, 3) != 0);
      end
      if (remaining > 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL round_timeout: got %0d bursts unfinished expected 0", remaining);
      end
      cl_req = '0;
      repeat (2) tick();
      check("sb_drain", LW'(exp_q.size()), '0);
      exp_q.delete();
   endtask

   logic [LW-1:0]  d3[4];
   logic [AW-1:0]  a3;
   logic [SW-1:0]  s3;
   logic [LVW-1:0] l3;

   initial begin
      rst_n = 1'b0;
      cl_req = '0; cl_last = '0; cl_start_addr = '0; cl_size_bytes = '0;
      cl_data = '0; cl_last_valid = '0; mem_gnt = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_mem_req", LW'(mem_req), '0);
      check("rst_cl_gnt", LW'(cl_gnt), '0);
      check("rst_busy", LW'(busy), '0);
      check("rst_owner", LW'(owner_id), '0);
      check("rst_err", LW'(err_abort), '0);
      check("rst_mem_last", LW'(mem_last), '0);
      check("rst_mem_data", mem_data, '0);
      tick();
      rst_n = 1'b1;

      // memory grant with no owner, distinct payload per client
      mem_gnt = 1'b1;
      for (int c = 0; c < N; c++) set_client(c, 1'b0, 1'b1, rand_line(), AW'($urandom), SW'($urandom), LVW'($urandom));
      repeat (3) begin
         @(negedge clk);
         check("idle_cl_gnt", LW'(cl_gnt), '0);
         check("idle_mem_req", LW'(mem_req), '0);
         tick();
      end

      // client 2 alone, 3 beats, memory always ready
      for (int b = 0; b < 4; b++) d3[b] = rand_line();
      a3 = AW'($urandom); s3 = SW'($urandom); l3 = LVW'($urandom);
      set_client(2, 1'b1, 1'b0, d3[0], a3, s3, l3);
      @(negedge clk);
      check("lat_idle_mem_req", LW'(mem_req), '0);
      for (int b = 0; b < 3; b++) begin
         tick();
         cl_data[2*LW +: LW] = d3[b];
         cl_last[2] = (b == 2);
         @(negedge clk);
         check("c2_mem_req", LW'(mem_req), LW'(1'b1));
         check("c2_cl_gnt", LW'(cl_gnt), LW'(4'b0100));
         check("c2_mem_last", LW'(mem_last), LW'(b == 2));
         check("c2_mem_data", mem_data, d3[b]);
         check("c2_addr", LW'(mem_start_addr), LW'(a3));
         check("c2_owner", LW'(owner_id), LW'(2));
      end
      tick();
      cl_req[2] = 1'b0;
      @(negedge clk);
      check("c2_busy_fall", LW'(busy), '0);
      check("c2_owner_hold", LW'(owner_id), LW'(2));

      // watchdog: client 1 stalls, client 3 waits and is served afterwards
      tick();
      mem_gnt = 1'b0;
      set_client(1, 1'b1, 1'b0, rand_line(), AW'($urandom), SW'($urandom), LVW'($urandom));
      tick();
      @(negedge clk);
      check("wd_owner", LW'(owner_id), LW'(1));
      check("wd_busy", LW'(busy), LW'(1'b1));
      tick();
      cl_req[1] = 1'b0;
      mem_gnt = 1'b1;
      set_client(3, 1'b1, 1'b1, d3[3], a3, s3, l3);
      for (int k = 1; k <= TO; k++) begin
         @(negedge clk);
         check("wd_err_abort", LW'(err_abort), LW'(k == TO));
         check("wd_no_gnt", LW'(cl_gnt), '0);
         check("wd_mem_req", LW'(mem_req), '0);
         if (k < TO) tick();
      end
      tick();
      @(negedge clk);
      check("wd_busy_after", LW'(busy), '0);
      check("wd_err_once", LW'(err_abort), '0);
      tick();
      @(negedge clk);
      check("wd_next_owner", LW'(owner_id), LW'(3));
      check("wd_next_gnt", LW'(cl_gnt), LW'(4'b1000));
      check("wd_next_data", mem_data, d3[3]);
      tick();
      cl_req[3] = 1'b0;

      // watchdog near-miss: request returns in the 15th low cycle
      tick();
      mem_gnt = 1'b0;
      set_client(0, 1'b1, 1'b0, rand_line(), AW'($urandom), SW'($urandom), LVW'($urandom));
      tick();
      @(negedge clk);
      check("nm_owner", LW'(owner_id), '0);
      tick();
      cl_req[0] = 1'b0;
      for (int k = 1; k < TO - 1; k++) begin
         @(negedge clk);
         check("nm_err_abort", LW'(err_abort), '0);
         tick();
      end
      cl_req[0] = 1'b1;
      cl_last[0] = 1'b1;
      mem_gnt = 1'b1;
      @(negedge clk);
      check("nm_err_abort_end", LW'(err_abort), '0);
      check("nm_busy", LW'(busy), LW'(1'b1));
      check("nm_gnt", LW'(cl_gnt), LW'(4'b0001));
      tick();
      cl_req[0] = 1'b0;
      mem_gnt = 1'b0;

      // reset asserted during beat 2 of a 4-beat burst
      tick();
      mem_gnt = 1'b1;
      set_client(2, 1'b1, 1'b0, d3[0], a3, s3, l3);
      tick();
      @(negedge clk);
      check("rb_beat1_gnt", LW'(cl_gnt), LW'(4'b0100));
      tick();
      cl_data[2*LW +: LW] = d3[1];
      #2;
      rst_n = 1'b0;
      #1;
      check("rb_cl_gnt", LW'(cl_gnt), '0);
      check("rb_mem_req", LW'(mem_req), '0);
      check("rb_busy", LW'(busy), '0);
      check("rb_owner", LW'(owner_id), '0);
      check("rb_mem_data", mem_data, '0);
      check("rb_mem_last", LW'(mem_last), '0);
      check("rb_addr", LW'(mem_start_addr), '0);
      tick();
      tick();
      rst_n = 1'b1;
      cl_data[2*LW +: LW] = d3[0];
      cl_last[2] = 1'b1;
      tick();
      @(negedge clk);
      check("rb_reissue_owner", LW'(owner_id), LW'(2));
      check("rb_reissue_gnt", LW'(cl_gnt), LW'(4'b0100));
      check("rb_reissue_data", mem_data, d3[0]);
      tick();
      cl_req[2] = 1'b0;
      mem_gnt = 1'b0;
      m_rr = 3;

      // randomized rounds
      tick();
      mon_en = 1'b1;
      run_round(4'b1011);
      repeat (25) run_round(N'($urandom_range(1, 15)));
      mon_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      n_bad++;
      $display("FAIL global_timeout: got no finish expected finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "timeout");
   end

endmodule
